// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcodes, state codes and aluop encodings for the MIPS control path
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_FUNCT = 3'd2,
        ALU_AND   = 3'd3,
        ALU_OR    = 3'd4
    } aluop_t;

    // Successor of DECODE; S_FETCH doubles as the "unsupported opcode" result.
    function automatic state_t decode_next(input logic [5:0] op, input logic en_bne,
                                           input logic en_imm);
        state_t nxt;
        case (op)
            OP_RTYPE:        nxt = S_RTYPEEX;
            OP_LW, OP_SW:    nxt = S_MEMADR;
            OP_BEQ:          nxt = S_BEQEX;
            OP_BNE:          nxt = en_bne ? S_BNEEX : S_FETCH;
            OP_ADDI:         nxt = S_IMMEX;
            OP_ANDI, OP_ORI: nxt = en_imm ? S_IMMEX : S_FETCH;
            OP_J:            nxt = S_JEX;
            default:         nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// rtl/mc_outdec.sv - combinational control-word decode from state, opcode, zero and mem_ready
module mc_outdec
    import mips_ctrl_pkg::*;
#(
    parameter bit EN_BNE      = 1'b1,
    parameter bit EN_IMMLOGIC = 1'b1
) (
    input  logic [3:0] state,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] aluop,
    output logic       zeroext,
    output logic       illegal
);

    state_t st;
    assign st = state_t'(state);

    always_comb begin
        iord     = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        pcen     = 1'b0;
        aluop    = ALU_ADD;
        zeroext  = 1'b0;
        illegal  = 1'b0;
        case (st)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                illegal = (decode_next(op, EN_BNE, EN_IMMLOGIC) == S_FETCH);
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALU_FUNCT;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
                alusrca = 1'b1;
                aluop   = ALU_SUB;
                pcsrc   = 2'b01;
                pcen    = (st == S_BEQEX) ? zero : ~zero;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                case (op)
                    OP_ANDI: begin aluop = ALU_AND; zeroext = 1'b1; end
                    OP_ORI:  begin aluop = ALU_OR;  zeroext = 1'b1; end
                    default: begin aluop = ALU_ADD; zeroext = 1'b0; end
                endcase
            end
            S_IMMWB: begin
                regwrite = 1'b1;
                zeroext  = (op == OP_ANDI) || (op == OP_ORI);
            end
            S_JEX: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS main controller: state register, sequencing and reset gating
module mc_controller
    import mips_ctrl_pkg::*;
#(
    parameter bit EN_BNE      = 1'b1,
    parameter bit EN_IMMLOGIC = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] aluop,
    output logic       zeroext,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] ir_op;
    logic [5:0] op_sel;
    logic       irwrite_raw;
    logic       memwrite_raw;
    logic       regwrite_raw;
    logic       pcen_raw;
    logic       illegal_raw;

    // The live opcode is trusted only in DECODE/IMMEX; later states use the copy taken in DECODE.
    assign op_sel = (state_q == S_DECODE || state_q == S_IMMEX) ? op : ir_op;
    assign state  = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_op   <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) ir_op <= op;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:  state_d = decode_next(op, EN_BNE, EN_IMMLOGIC);
            S_MEMADR:  state_d = (ir_op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_IMMEX:   state_d = S_IMMWB;
            default:   state_d = S_FETCH;
        endcase
    end

    mc_outdec #(
        .EN_BNE      (EN_BNE),
        .EN_IMMLOGIC (EN_IMMLOGIC)
    ) u_outdec (
        .state     (state_q),
        .op        (op_sel),
        .zero      (zero),
        .mem_ready (mem_ready),
        .iord      (iord),
        .irwrite   (irwrite_raw),
        .memwrite  (memwrite_raw),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .regwrite  (regwrite_raw),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .pcen      (pcen_raw),
        .aluop     (aluop),
        .zeroext   (zeroext),
        .illegal   (illegal_raw)
    );

    // Architectural strobes are suppressed during reset so a stalled access cannot complete.
    assign irwrite  = irwrite_raw  & ~reset;
    assign memwrite = memwrite_raw & ~reset;
    assign regwrite = regwrite_raw & ~reset;
    assign pcen     = pcen_raw     & ~reset;
    assign illegal  = illegal_raw  & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - table-driven self-checking bench for mc_controller
module tb_mc_controller;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        zero;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] ctl;
    } vec_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] RT = 6'b000000, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
    localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;

    logic clk = 1'b0;
    logic reset, zero, mem_ready;
    logic [5:0] op;

    logic iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca, pcen, zeroext, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] aluop;
    logic [3:0] state;

    logic b_iord, b_irwrite, b_memwrite, b_regdst, b_memtoreg, b_regwrite, b_alusrca, b_pcen;
    logic b_zeroext, b_illegal;
    logic [1:0] b_alusrcb, b_pcsrc;
    logic [2:0] b_aluop;
    logic [3:0] b_state;

    int npass = 0;
    int ntot  = 0;
    vec_t vecs[$];

    logic [16:0] K_FETCH, K_FSTALL, K_DEC, K_ILL, K_MADR, K_MRD, K_MWB, K_MWR, K_REX, K_RWB;
    logic [16:0] K_BR_T, K_BR_N, K_IADD, K_IORI, K_IANDI, K_IWB, K_IWBZ, K_JEX;

    always #5 clk = ~clk;

    mc_controller #(.EN_BNE(1'b1), .EN_IMMLOGIC(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .pcen(pcen), .aluop(aluop), .zeroext(zeroext),
        .illegal(illegal), .state(state)
    );

    mc_controller #(.EN_BNE(1'b0), .EN_IMMLOGIC(1'b0)) dut_min (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .iord(b_iord), .irwrite(b_irwrite), .memwrite(b_memwrite), .regdst(b_regdst),
        .memtoreg(b_memtoreg), .regwrite(b_regwrite), .alusrca(b_alusrca), .alusrcb(b_alusrcb),
        .pcsrc(b_pcsrc), .pcen(b_pcen), .aluop(b_aluop), .zeroext(b_zeroext),
        .illegal(b_illegal), .state(b_state)
    );

    function automatic logic [16:0] ctl(input logic io, irw, mw, rd, m2r, rw, asa,
                                        input logic [1:0] asb, pcs, input logic pce,
                                        input logic [2:0] alu, input logic zx, ill);
        return {io, irw, mw, rd, m2r, rw, asa, asb, pcs, pce, alu, zx, ill};
    endfunction

    task automatic add(input logic r, input logic [5:0] o, input logic z, input logic m,
                       input logic [3:0] s, input logic [16:0] c);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.mr = m; v.st = s; v.ctl = c;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic [5:0] o, input logic z, input logic m);
        @(negedge clk);
        reset = r; op = o; zero = z; mem_ready = m;
        #1;
    endtask

    initial begin
        K_FETCH  = ctl(0,1,0,0,0,0,0,2'b01,2'b00,1,3'd0,0,0);
        K_FSTALL = ctl(0,0,0,0,0,0,0,2'b01,2'b00,0,3'd0,0,0);
        K_DEC    = ctl(0,0,0,0,0,0,0,2'b11,2'b00,0,3'd0,0,0);
        K_ILL    = ctl(0,0,0,0,0,0,0,2'b11,2'b00,0,3'd0,0,1);
        K_MADR   = ctl(0,0,0,0,0,0,1,2'b10,2'b00,0,3'd0,0,0);
        K_MRD    = ctl(1,0,0,0,0,0,0,2'b00,2'b00,0,3'd0,0,0);
        K_MWB    = ctl(0,0,0,0,1,1,0,2'b00,2'b00,0,3'd0,0,0);
        K_MWR    = ctl(1,0,1,0,0,0,0,2'b00,2'b00,0,3'd0,0,0);
        K_REX    = ctl(0,0,0,0,0,0,1,2'b00,2'b00,0,3'd2,0,0);
        K_RWB    = ctl(0,0,0,1,0,1,0,2'b00,2'b00,0,3'd0,0,0);
        K_BR_T   = ctl(0,0,0,0,0,0,1,2'b00,2'b01,1,3'd1,0,0);
        K_BR_N   = ctl(0,0,0,0,0,0,1,2'b00,2'b01,0,3'd1,0,0);
        K_IADD   = ctl(0,0,0,0,0,0,1,2'b10,2'b00,0,3'd0,0,0);
        K_IORI   = ctl(0,0,0,0,0,0,1,2'b10,2'b00,0,3'd4,1,0);
        K_IANDI  = ctl(0,0,0,0,0,0,1,2'b10,2'b00,0,3'd3,1,0);
        K_IWB    = ctl(0,0,0,0,0,1,0,2'b00,2'b00,0,3'd0,0,0);
        K_IWBZ   = ctl(0,0,0,0,0,1,0,2'b00,2'b00,0,3'd0,1,0);
        K_JEX    = ctl(0,0,0,0,0,0,0,2'b00,2'b10,1,3'd0,0,0);

        add(1, LW, 0, 1, 0, K_FSTALL);
        add(0, LW, 0, 1, 0, K_FETCH); add(0, LW, 0, 1, 1, K_DEC); add(0, LW, 0, 1, 2, K_MADR);
        add(0, LW, 0, 1, 3, K_MRD);   add(0, LW, 0, 1, 4, K_MWB);
        add(0, LW, 0, 1, 0, K_FETCH); add(0, LW, 0, 0, 1, K_DEC); add(0, LW, 0, 0, 2, K_MADR);
        add(0, LW, 0, 0, 3, K_MRD);   add(0, LW, 0, 0, 3, K_MRD); add(0, LW, 0, 1, 3, K_MRD);
        add(0, LW, 0, 1, 4, K_MWB);
        add(0, BEQ, 1, 1, 0, K_FETCH); add(0, BEQ, 1, 1, 1, K_DEC); add(0, BEQ, 1, 1, 8, K_BR_T);
        add(0, BEQ, 0, 1, 0, K_FETCH); add(0, BEQ, 0, 1, 1, K_DEC); add(0, BEQ, 0, 1, 8, K_BR_N);
        add(0, BNE, 0, 1, 0, K_FETCH); add(0, BNE, 0, 1, 1, K_DEC); add(0, BNE, 0, 1, 12, K_BR_T);
        add(0, BNE, 1, 1, 0, K_FETCH); add(0, BNE, 1, 1, 1, K_DEC); add(0, BNE, 1, 1, 12, K_BR_N);
        add(0, RT, 0, 1, 0, K_FETCH);  add(0, RT, 0, 1, 1, K_DEC);  add(0, RT, 0, 1, 6, K_REX);
        add(0, RT, 0, 1, 7, K_RWB);
        add(0, ADDI, 0, 1, 0, K_FETCH); add(0, ADDI, 0, 1, 1, K_DEC); add(0, ADDI, 0, 1, 9, K_IADD);
        add(0, ADDI, 0, 1, 10, K_IWB);
        add(0, ORI, 0, 1, 0, K_FETCH); add(0, ORI, 0, 1, 1, K_DEC); add(0, ORI, 0, 1, 9, K_IORI);
        add(0, ORI, 0, 1, 10, K_IWBZ);
        add(0, ANDI, 0, 1, 0, K_FETCH); add(0, ANDI, 0, 1, 1, K_DEC); add(0, ANDI, 0, 1, 9, K_IANDI);
        add(0, ANDI, 0, 1, 10, K_IWBZ);
        add(0, JMP, 0, 1, 0, K_FETCH); add(0, JMP, 0, 1, 1, K_DEC); add(0, JMP, 0, 1, 11, K_JEX);
        add(0, BAD, 0, 1, 0, K_FETCH); add(0, BAD, 0, 1, 1, K_ILL);
        add(0, SW, 0, 0, 0, K_FSTALL); add(0, SW, 0, 1, 0, K_FETCH); add(0, SW, 0, 1, 1, K_DEC);
        add(0, SW, 0, 1, 2, K_MADR);   add(0, SW, 0, 1, 5, K_MWR);
        add(0, SW, 0, 1, 0, K_FETCH);  add(0, SW, 0, 1, 1, K_DEC); add(0, SW, 0, 1, 2, K_MADR);
        add(0, SW, 0, 0, 5, K_MWR);    add(1, SW, 0, 0, 5, K_MRD);
        add(0, JMP, 0, 0, 0, K_FSTALL); add(0, JMP, 0, 1, 0, K_FETCH); add(0, JMP, 0, 1, 1, K_DEC);
        add(0, JMP, 0, 1, 11, K_JEX);  add(0, JMP, 0, 1, 0, K_FETCH);

        reset = 1'b1; op = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].mr);
            chk($sformatf("row%0d state", i), {28'd0, state}, {28'd0, vecs[i].st});
            chk($sformatf("row%0d ctl", i),
                {15'd0, iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
                 pcsrc, pcen, aluop, zeroext, illegal},
                {15'd0, vecs[i].ctl});
        end

        // BNE and ORI on the reduced build must decode as illegal with no strobes.
        drive(1, BNE, 0, 1);
        drive(0, BNE, 0, 1);
        chk("min bne fetch state", {28'd0, b_state}, 32'd0);
        drive(0, BNE, 0, 1);
        chk("min bne decode state", {28'd0, b_state}, 32'd1);
        chk("min bne illegal", {31'd0, b_illegal}, 32'd1);
        chk("min bne strobes", {28'd0, b_irwrite, b_pcen, b_memwrite, b_regwrite}, 32'd0);
        drive(0, BNE, 0, 1);
        chk("min bne back to fetch", {28'd0, b_state}, 32'd0);
        chk("min bne illegal cleared", {31'd0, b_illegal}, 32'd0);
        chk("full bne taken pcen", {31'd0, pcen}, 32'd1);
        chk("full bne state", {28'd0, state}, 32'd12);
        drive(1, ORI, 0, 1);
        drive(0, ORI, 0, 1);
        drive(0, ORI, 0, 1);
        chk("min ori illegal", {31'd0, b_illegal}, 32'd1);
        drive(0, ORI, 0, 1);
        chk("min ori back to fetch", {28'd0, b_state}, 32'd0);
        chk("full ori immex", {28'd0, state}, 32'd9);

        // Reset asserted in DECODE of an illegal opcode must mask the pulse.
        drive(0, BAD, 0, 1);
        drive(0, BAD, 0, 1);
        drive(1, BAD, 0, 1);
        chk("illegal masked by reset", {31'd0, b_illegal}, 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle main controller for the MIPS datapath. It replaces the single-cycle main decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several clocks, and stalls on a memory-ready handshake. Opcode-class support (BNE, ANDI/ORI) is enabled by parameter. It drives the shared-memory multicycle datapath and feeds `aluop` to the existing ALU decoder.

## Interface
- `EN_BNE`, 1: 1 = decode opcode 000101 (BNE); 0 = treat it as illegal.
- `EN_IMMLOGIC`, 1: 1 = decode ANDI (001100) and ORI (001101); 0 = treat them as illegal.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: instruction opcode, sampled only in DECODE.
- `zero` in 1: ALU zero flag, used in BEQEX/BNEEX.
- `mem_ready` in 1: memory completes the current access this cycle.
- `iord`, `irwrite`, `memwrite`, `regdst`, `memtoreg`, `regwrite`, `alusrca` out 1: standard multicycle datapath controls.
- `alusrcb` out 2: 00 = B, 01 = const 4, 10 = sign/zero-extended imm, 11 = imm<<2.
- `pcsrc` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pcen` out 1: PC write enable; the branch condition is folded in.
- `aluop` out 3: 000 add, 001 sub, 010 use funct, 011 and, 100 or.
- `zeroext` out 1: selects zero-extension for immediates (ANDI/ORI).
- `illegal` out 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `state` out 4: current state, for debug and the bench.

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, IMMEX 9, IMMWB 10, JEX 11, BNEEX 12. Codes 13–15 are unreachable and go to FETCH.
- FETCH:
  - `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=000, `pcsrc`=00.
  - If `mem_ready`=1: `irwrite`=1, `pcen`=1, next state DECODE.
  - Otherwise hold in FETCH with `irwrite`=0 and `pcen`=0.
- DECODE:
  - `alusrca`=0, `alusrcb`=11, `aluop`=000 (branch target computed into ALUOut).
  - Next state by `op`:
    - 000000 → RTYPEEX
    - 100011 or 101011 → MEMADR
    - 000100 → BEQEX
    - 000101 → BNEEX (only when EN_BNE=1)
    - 001000 → IMMEX
    - 001100 or 001101 → IMMEX (only when EN_IMMLOGIC=1)
    - 000010 → JEX
    - anything else → FETCH with `illegal`=1
- MEMADR: `alusrca`=1, `alusrcb`=10, `aluop`=000. Next state MEMRD for LW, MEMWR for SW; the opcode is held in the IR.
- MEMRD:
  - `iord`=1; hold while `mem_ready`=0.
  - On `mem_ready`=1, go to MEMWB.
- MEMWB: `regdst`=0, `memtoreg`=1, `regwrite`=1, then FETCH.
- MEMWR:
  - `iord`=1, `memwrite`=1 for every cycle in this state.
  - On `mem_ready`=1, go to FETCH.
- RTYPEEX: `alusrca`=1, `alusrcb`=00, `aluop`=010, then RTYPEWB.
- RTYPEWB: `regdst`=1, `memtoreg`=0, `regwrite`=1, then FETCH.
- BEQEX / BNEEX:
  - `alusrca`=1, `alusrcb`=00, `aluop`=001, `pcsrc`=01.
  - `pcen` = `zero` (BEQ) or `~zero` (BNE); then FETCH.
- IMMEX:
  - `alusrca`=1, `alusrcb`=10.
  - ADDI: `aluop`=000, `zeroext`=0.
  - ANDI: `aluop`=011, `zeroext`=1.
  - ORI: `aluop`=100, `zeroext`=1.
  - Then IMMWB.
- IMMWB: `regdst`=0, `memtoreg`=0, `regwrite`=1, `zeroext` held as in IMMEX; then FETCH.
- JEX: `pcsrc`=10, `pcen`=1, then FETCH.
- Any control not listed for a state is 0.

## Timing
- Reset:
  - `reset`=1 at a rising edge loads FETCH.
  - While `reset`=1, `irwrite`, `pcen`, `memwrite`, `regwrite` and `illegal` are forced to 0.
  - Reset has priority in every state, including mid-stall in MEMRD/MEMWR. No partial write completes after the reset edge.
- Output timing:
  - All outputs are combinational from `state`. The exceptions are `pcen`/`irwrite` (gated by `mem_ready` or `zero`) and `illegal`/IMMEX selects (decoded from `op`).
  - State update has 1-cycle latency.
- Cycle counts with `mem_ready` tied to 1:
  - LW 5, SW 4, R-type 4, ADDI/ANDI/ORI 4, BEQ/BNE 3, J 3, illegal 2.
  - Each `mem_ready`=0 cycle in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.
- `op` must be stable in DECODE and IMMEX; it is not sampled elsewhere.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J);
  - the 4-bit state enum;
  - the `aluop` encodings.
  The ALU decoder also imports this package.
- One sub-module, `mc_outdec`: purely combinational, maps `state`, `op`, `zero` and `mem_ready` to the control word. `mc_controller` keeps the state register, next-state logic and reset gating.

## Test plan
- LW, `mem_ready`=1 throughout → `state` 0,1,2,3,4,0. Cycle 5 has `regwrite`=1, `memtoreg`=1, `regdst`=0.
- LW with `mem_ready`=0 for 2 cycles in MEMRD → MEMRD lasts 3 cycles, 7 cycles total. `iord`=1 and `regwrite`=0 throughout MEMRD.
- BEQ, `zero`=1 → BEQEX has `pcen`=1, `pcsrc`=01, `aluop`=001. Repeat with `zero`=0 → `pcen`=0, next state FETCH.
- EN_BNE=0 with op 000101 → DECODE pulses `illegal`=1 for 1 cycle, next state FETCH, no strobes asserted. With EN_BNE=1 and `zero`=0 → `pcen`=1.
- ORI with EN_IMMLOGIC=1 → IMMEX has `aluop`=100, `zeroext`=1, `alusrcb`=10. IMMWB has `regwrite`=1, `regdst`=0.
- SW stalled in MEMWR with `mem_ready`=0, then `reset`=1 for one cycle → `state`=0 on the next cycle, `memwrite`=0 from the reset cycle onward. FETCH waits for `mem_ready` before `irwrite`.
